// File: rtl/ibex_bus_arbiter.sv
// Two-host (instr/data) to one-device memory arbiter.
// In-order ID FIFO routes device responses back to the granting host.
module ibex_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [3:0]  outstanding_o,
    output logic        spurious_rvalid_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [3:0] Depth = 4'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(MaxOutstanding - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_I,
        HOLD_D
    } state_e;

    state_e state_q, state_d;

    // owner: 0 = instr host, 1 = data host
    logic owner;
    logic req;
    logic gnt;
    logic pop;
    logic head;
    logic full;
    logic empty;
    logic last_q;
    logic spurious_q;
    logic [3:0] count_q;
    logic [MaxOutstanding-1:0] id_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == Depth);
    assign empty = (count_q == 4'd0);
    assign gnt   = req & mem_gnt_i;
    assign pop   = rst_ni & mem_rvalid_i & ~empty;
    assign head  = id_q[rd_ptr_q];

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: lock the owner while its request waits for a grant
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req && !mem_gnt_i) begin
                    state_d = owner ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I: begin
                if (mem_gnt_i || !instr_req_i) begin
                    state_d = IDLE;
                end
            end
            HOLD_D: begin
                if (mem_gnt_i || !data_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner selection and device request
    always_comb begin
        owner = 1'b0;
        req   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_req_i && data_req_i) begin
                    owner = RoundRobin ? ~last_q : 1'b1;
                end else begin
                    owner = data_req_i;
                end
                req = ~full & (instr_req_i | data_req_i);
            end
            HOLD_I: begin
                owner = 1'b0;
                req   = instr_req_i;
            end
            HOLD_D: begin
                owner = 1'b1;
                req   = data_req_i;
            end
            default: begin
                owner = 1'b0;
                req   = 1'b0;
            end
        endcase
        req = req & rst_ni;
    end

    // Response-routing FIFO of granted host IDs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            if (gnt) begin
                id_q[wr_ptr_q] <= owner;
                wr_ptr_q       <= bump(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= bump(rd_ptr_q);
            end
            count_q <= count_q + {3'b0, gnt} - {3'b0, pop};
        end
    end

    // Last granted host for round-robin, sticky spurious-response flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            if (gnt) begin
                last_q <= owner;
            end
            if (mem_rvalid_i && empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign instr_gnt_o    = gnt & ~owner;
    assign data_gnt_o     = gnt & owner;
    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign mem_req_o   = req;
    assign mem_we_o    = (req & owner) ? data_we_i : 1'b0;
    assign mem_be_o    = (req & owner) ? data_be_i : 4'hf;
    assign mem_addr_o  = (req & owner) ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = (req & owner) ? data_wdata_i : 32'h0;

    assign outstanding_o     = count_q;
    assign spurious_rvalid_o = spurious_q;

endmodule

// File: doc/ibex_bus_arbiter.md
# ibex_bus_arbiter

Two-host to one-device arbiter for the Ibex core's instruction and data memory interfaces in formal and simulation harnesses. It shares one req/gnt/rvalid memory port between the instruction-fetch host and the load/store host. It keeps each host's request stable until the device grants it. Responses are routed back through an in-order ID FIFO. It sits between `ibex_core` and the single memory model or bus slave.

## Interface
- `MaxOutstanding`, default 2: depth of the response-routing FIFO, i.e. the maximum number of granted-but-unanswered transactions. Legal range 1..8.
- `RoundRobin`, default 0: selects the arbitration policy. 0 means fixed priority with data over instr. 1 means alternate between hosts when both request.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `instr_req_i` in 1, `instr_addr_i` in 32: instruction host request.
- `instr_gnt_o` out 1, `instr_rvalid_o` out 1, `instr_rdata_o` out 32, `instr_err_o` out 1: instruction host grant and response.
- `data_req_i` in 1, `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32: data host request.
- `data_gnt_o` out 1, `data_rvalid_o` out 1, `data_rdata_o` out 32, `data_err_o` out 1: data host grant and response.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_be_o` out 4, `mem_addr_o` out 32, `mem_wdata_o` out 32: device request.
- `mem_gnt_i` in 1, `mem_rvalid_i` in 1, `mem_rdata_i` in 32, `mem_err_i` in 1: device grant and response.
- `outstanding_o` out 4: current FIFO occupancy.
- `spurious_rvalid_o` out 1: sticky flag set by a device response that has no matching outstanding transaction.

## Operation
- **FSM states:** IDLE, HOLD_I, HOLD_D. In reset, the FSM is in IDLE.
- **IDLE:**
  - If the FIFO is not full, pick the owner from the requesting hosts. A lone requester wins.
  - If both hosts request and `RoundRobin`=0, data wins.
  - If both hosts request and `RoundRobin`=1, the host not granted last wins. The `last` register resets to instr, so data wins the first tie.
  - Drive `mem_*` from the owner and assert `mem_req_o`.
- **Stall in IDLE:** if `mem_req_o`=1 and `mem_gnt_i`=0, go to HOLD_I or HOLD_D according to the owner.
- **HOLD_x:**
  - The owner is locked to host x regardless of other requests.
  - `mem_req_o` = `x_req_i`.
  - On `mem_gnt_i`, return to IDLE.
  - If `x_req_i` deasserts without a grant (protocol violation), return to IDLE and issue no grant.
- **Grant:** `x_gnt_o` = `mem_req_o` & `mem_gnt_i` & (owner == x). The non-owner's grant is 0.
- **On grant:**
  - Push the owner ID into the FIFO.
  - Update `last` to the owner.
- **Full FIFO:** `mem_req_o`=0 and both grants are 0. The FSM stays in IDLE. A HOLD state cannot coexist with a full FIFO, because HOLD is entered only while not full and no push occurs until the grant.
- **Response:** on `mem_rvalid_i` with the FIFO non-empty, pop the head ID. Assert rvalid only toward that host, forwarding `mem_err_i`.
- **Read data:** `mem_rdata_i` is broadcast on both `*_rdata_o`.
- **Spurious response:** `mem_rvalid_i` with an empty FIFO is dropped. It sets `spurious_rvalid_o`, which is cleared only by reset.
- **Simultaneous push and pop:** the count is unchanged and FIFO order is preserved (pop head, push tail).
- **Full and popping in the same cycle:** still no grant that cycle. This rule keeps any rvalid-to-req combinational path out of the design.
- **FIFO pointers:** wrap modulo `MaxOutstanding`. The count width is 4 bits.
- **Protocol assumption:** the device answers in order.

## Timing
- The request path is combinational: host req to `mem_req_o` has zero cycles of latency.
- Grant and rvalid to the hosts are combinational from `mem_gnt_i` and `mem_rvalid_i`.
- FSM state, FIFO contents, `outstanding_o`, `last` and `spurious_rvalid_o` update on the rising edge of `clk_i`.
- **Reset values:**
  - `outstanding_o`=0 and `spurious_rvalid_o`=0.
  - `mem_req_o`, `*_gnt_o` and `*_rvalid_o` are forced to 0 while `rst_ni`=0.
  - Data and address outputs are don't-care while `mem_req_o`=0, but are driven from the instr host in that case.
- **Reset mid-operation:**
  - The FIFO is flushed and the FSM returns to IDLE.
  - Responses arriving after reset for pre-reset grants set `spurious_rvalid_o`.
- The wrapper's external memory signals are unconstrained random. The block must never emit a grant or rvalid to a host that has no matching request or outstanding transaction.

## Test plan
- **Priority:** instr and data both request with `addr`=0x100/0x200 and `mem_gnt_i`=1 constantly.
  - `RoundRobin`=0: data is granted every cycle and instr is starved.
  - `RoundRobin`=1: grants alternate D,I,D,I.
- **Hold:** data requests at 0x40 with `mem_gnt_i`=0 for 3 cycles while instr also requests.
  - `mem_addr_o` stays 0x40 in HOLD_D.
  - In cycle 4, `mem_gnt_i`=1 gives `data_gnt_o`=1, and instr is granted in the next cycle.
- **Full:** with `MaxOutstanding`=2, grant two instr fetches with no rvalid.
  - `outstanding_o`=2 and `mem_req_o`=0 in the third cycle.
  - One rvalid pops the FIFO, and the next cycle shows `mem_req_o`=1.
- **Routing:** grant I, then D, then I. Return three rvalids with rdata 0xA, 0xB, 0xC and `err`=0,1,0.
  - `instr_rvalid_o` carries 0xA.
  - `data_rvalid_o` carries 0xB with `data_err_o`=1.
  - `instr_rvalid_o` carries 0xC.
- **Spurious and reset:** assert `mem_rvalid_i` with an empty FIFO.
  - No host rvalid is asserted and `spurious_rvalid_o`=1.
  - Pulse `rst_ni` low with 1 outstanding: the flag clears and `outstanding_o`=0.
  - A later rvalid sets the flag again.
- **Push/pop same cycle:** with 1 outstanding, grant and respond in the same cycle. `outstanding_o` stays at 1 and the routed ID is the older entry.
